// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tank_pkg
// Brief    : Shared types and constants for the reservoir plant model.
// Revision : 1.0 - initial release
// ============================================================================
package tank_pkg;

  localparam int TANK_W = 8;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOW    = 2'd1,
    NORMAL = 2'd2,
    FULL   = 2'd3
  } tank_state_t;

  // Legal {h,m,l} codes, ordered by rising level.
  localparam logic [2:0] SENSOR_CODE [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

  function automatic tank_state_t classifyLevel(input int lvl, input int lowTh, input int cap);
    if (lvl == 0)          return EMPTY;
    else if (lvl < lowTh)  return LOW;
    else if (lvl < cap)    return NORMAL;
    else                   return FULL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tank_level_sim_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Brief    : Divides clk by TICK_DIV, producing a one-cycle tick strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            c_cntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cntW-1:0] c_last = c_cntW'(TICK_DIV - 1);

  logic [c_cntW-1:0] r_tickCnt;

  assign tick = (r_tickCnt == c_last);

  always_ff @(posedge clk) begin
    if (rst)       r_tickCnt <= '0;
    else if (tick) r_tickCnt <= '0;
    else           r_tickCnt <= r_tickCnt + 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/tank_level_sim.sv
`default_nettype none
// ============================================================================
// Module   : tank_level_sim
// Brief    : Tank volume integrator driving h/m/l level sensors and a state
//            class. TANK_SENSOR_HYST_EN enables hysteretic sensor bits.
// Revision : 1.0 - initial release
// ============================================================================
module tank_level_sim
  import tank_pkg::*;
#(
  parameter int W          = TANK_W,
  parameter int CAP        = 255,
  parameter int INIT_LEVEL = 0,
  parameter int TICK_DIV   = 4,
  parameter int FILL_RATE  = 4,
  parameter int DRIP_RATE  = 1,
  parameter int SPRAY_RATE = 3,
  parameter int L_TH       = 64,
  parameter int M_TH       = 128,
  parameter int H_TH       = 192,
  parameter int HYST       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ve,
  input  logic         got,
  input  logic         asp,
  output logic         h,
  output logic         m,
  output logic         l,
  output logic [W-1:0] level,
  output logic [1:0]   state,
  output logic         ovf,
  output logic         dry
);

  localparam logic signed [W+1:0] c_fill  = (W+2)'(FILL_RATE);
  localparam logic signed [W+1:0] c_drip  = (W+2)'(DRIP_RATE);
  localparam logic signed [W+1:0] c_spray = (W+2)'(SPRAY_RATE);
  localparam logic signed [W+1:0] c_cap   = (W+2)'(CAP);
  localparam int                  c_th [3] = '{L_TH, M_TH, H_TH};

  generate
    if (!(L_TH > 0 && L_TH < M_TH && M_TH < H_TH && H_TH <= CAP &&
          CAP < (2 ** W) && HYST < L_TH && TICK_DIV >= 1)) begin : g_badCfg
      $error("tank_level_sim: inconsistent parameter set");
    end
  endgenerate

  logic                w_tick;
  logic signed [W+1:0] w_sum;
  logic [W-1:0]        r_level;
  logic                r_ovf;
  logic                r_dry;
  tank_state_t         r_state;
  logic [2:0]          w_sens;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tickGen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Net change is additive; two guard bits keep the sign and the overshoot.
  assign w_sum = $signed({2'b00, r_level})
               + (ve  ? c_fill  : '0)
               - (got ? c_drip  : '0)
               - (asp ? c_spray : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= W'(INIT_LEVEL);
      r_ovf   <= 1'b0;
      r_dry   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_dry <= 1'b0;
      if (w_tick) begin
        if (w_sum > c_cap) begin
          r_level <= W'(CAP);
          r_ovf   <= 1'b1;
        end else if (w_sum < 0) begin
          r_level <= '0;
          r_dry   <= 1'b1;
        end else begin
          r_level <= w_sum[W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= classifyLevel(INIT_LEVEL, L_TH, CAP);
    else     r_state <= classifyLevel(int'(r_level), L_TH, CAP);
  end

  generate
    for (genvar i = 0; i < 3; i++) begin : g_sensor
      localparam logic [W-1:0] c_set   = W'(c_th[i]);
      localparam logic         c_rstVal = (INIT_LEVEL >= c_th[i]) ? 1'b1 : 1'b0;
      logic r_bit;
`ifdef TANK_SENSOR_HYST_EN
      // Clear point sits HYST below the set point, floored at zero.
      localparam logic [W-1:0] c_clr = W'((c_th[i] > HYST) ? (c_th[i] - HYST) : 0);
      always_ff @(posedge clk) begin
        if (rst)                    r_bit <= c_rstVal;
        else if (r_level >= c_set)  r_bit <= 1'b1;
        else if (r_level <  c_clr)  r_bit <= 1'b0;
      end
`else
      always_ff @(posedge clk) begin
        if (rst) r_bit <= c_rstVal;
        else     r_bit <= (r_level >= c_set);
      end
`endif
      assign w_sens[i] = r_bit;
    end
  endgenerate

  assign level = r_level;
  assign ovf   = r_ovf;
  assign dry   = r_dry;
  assign state = r_state;
  assign l     = w_sens[0];
  assign m     = w_sens[1];
  assign h     = w_sens[2];

endmodule
`default_nettype wire
